// File: rtl/uart_tx.sv
// uart_tx - byte-serial UART transmitter.
//
// Frames each accepted byte as: one start bit (low), eight data bits LSB
// first, an optional parity bit, then one or two stop bits (high). Only one
// frame is in flight at a time; a send request while a frame is running is
// dropped, and there is no queueing.
//
// Parameters:
//   CLK_HZ    - system clock frequency in Hz
//   BAUD      - line rate in bits per second
//   PARITY    - 0 = none, 1 = even, 2 = odd
//   STOP_BITS - number of stop bits, 1 or 2
//
// Ports:
//   clk     - single rising-edge clock
//   rst_n   - synchronous active-low reset
//   send    - one-cycle request to transmit tx_data (honoured only when idle)
//   tx_data - byte to transmit, sampled on the accepting edge only
//   tx_busy - registered, high while a frame is in progress
//   tx_done - registered one-cycle pulse on the edge that ends a frame
//   tx      - registered serial line, idles high

module uart_tx #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int BCNT_W       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  // Reject configurations the bit timer or framing cannot represent.
  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_rate
      $error("uart_tx: CLK_HZ / BAUD must be at least 2");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
      $error("uart_tx: PARITY must be 0, 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [2:0]        bidx_q, bidx_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;

  // Next-state logic. The line value is computed one cycle ahead so that tx
  // comes straight from a flop: every transition that starts a new bit also
  // loads the level that bit will drive. Parity is captured from the byte at
  // accept time, since the shift register no longer holds it later.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bit_end = (bcnt_q == BCNT_LAST);

    if (state_q != S_IDLE) begin
      bcnt_d = bit_end ? '0 : bcnt_q + BCNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (send) begin
          shift_d = tx_data;
          par_d   = (PARITY == 2) ? ~(^tx_data) : ^tx_data;
          bcnt_d  = '0;
          bidx_d  = 3'd0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          bidx_d  = 3'd0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (bidx_q == 3'd7) begin
            bidx_d = 3'd0;
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bidx_d  = bidx_q + 3'd1;
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          bidx_d  = 3'd0;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (bidx_q == STOP_LAST) begin
            bidx_d  = 3'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            bidx_d = bidx_q + 3'd1;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        bcnt_d  = '0;
        bidx_d  = 3'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers. Reset abandons any frame in progress and
  // forces the line high on the very next cycle without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      bidx_q  <= 3'd0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx - self-checking bench for uart_tx.
//
// Four transmitters share one clock and reset, all at 4 clocks per bit:
//   0: no parity, 1 stop bit     1: even parity, 1 stop bit
//   2: odd parity, 1 stop bit    3: no parity, 2 stop bits
// Each send pushes the full cycle-by-cycle expectation of (tx, tx_busy,
// tx_done) into a queue; the checker pops one entry per clock.

module tb_uart_tx;

  localparam int CPB = 4;

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       has_par;
    logic       par_bit;
    int         len;
  } vec_t;

  typedef struct {
    logic tx;
    logic busy;
    logic done;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] send_r;
  logic [7:0] data_r [4];
  logic       tx0, tx1, tx2, tx3;
  logic       busy0, busy1, busy2, busy3;
  logic       done0, done1, done2, done3;
  logic [3:0] tx_w, busy_w, done_w;

  exp_t exp_q[$];
  vec_t vecs[8];
  int   checks;
  int   fails;

  assign tx_w   = {tx3, tx2, tx1, tx0};
  assign busy_w = {busy3, busy2, busy1, busy0};
  assign done_w = {done3, done2, done1, done0};

  uart_tx #(.CLK_HZ(16), .BAUD(4), .PARITY(0), .STOP_BITS(1)) dut_none (
    .clk(clk), .rst_n(rst_n), .send(send_r[0]), .tx_data(data_r[0]),
    .tx_busy(busy0), .tx_done(done0), .tx(tx0)
  );

  uart_tx #(.CLK_HZ(16), .BAUD(4), .PARITY(1), .STOP_BITS(1)) dut_even (
    .clk(clk), .rst_n(rst_n), .send(send_r[1]), .tx_data(data_r[1]),
    .tx_busy(busy1), .tx_done(done1), .tx(tx1)
  );

  uart_tx #(.CLK_HZ(16), .BAUD(4), .PARITY(2), .STOP_BITS(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .send(send_r[2]), .tx_data(data_r[2]),
    .tx_busy(busy2), .tx_done(done2), .tx(tx2)
  );

  uart_tx #(.CLK_HZ(16), .BAUD(4), .PARITY(0), .STOP_BITS(2)) dut_stop2 (
    .clk(clk), .rst_n(rst_n), .send(send_r[3]), .tx_data(data_r[3]),
    .tx_busy(busy3), .tx_done(done3), .tx(tx3)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so a stuck run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compareBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drives a one-cycle send (called just after a rising edge), then queues
  // the expected line/busy/done value for every clock of the frame. Entry j
  // is what should be seen just after edge A+j, where A accepts the send.
  task automatic applyStimulus(input int sel, input logic [7:0] data,
                               input logic has_par, input logic par_bit,
                               input int len, input bit with_tail);
    exp_t e;
    int   b;
    send_r[sel] = 1'b1;
    data_r[sel] = data;
    for (int j = 0; j < len; j++) begin
      b = j / CPB;
      if (b == 0)                   e.tx = 1'b0;
      else if (b <= 8)              e.tx = data[b-1];
      else if (b == 9 && has_par)   e.tx = par_bit;
      else                          e.tx = 1'b1;
      e.busy = 1'b1;
      e.done = 1'b0;
      exp_q.push_back(e);
    end
    e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b1;
    exp_q.push_back(e);
    if (with_tail) begin
      e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b0;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    send_r[sel] = 1'b0;
    data_r[sel] = 8'($urandom);
  endtask

  // Pops and compares one expectation per clock until the queue is empty.
  // inject_at >= 0 pulses an extra send (data 0x00) after that entry, which
  // the transmitter must ignore because it is still busy.
  task automatic checkOutput(input int sel, input int inject_at);
    exp_t e;
    int   j;
    j = 0;
    while (exp_q.size() > 0) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      e = exp_q.pop_front();
      compareBit($sformatf("u%0d.tx[%0d]", sel, j), tx_w[sel], e.tx);
      compareBit($sformatf("u%0d.busy[%0d]", sel, j), busy_w[sel], e.busy);
      compareBit($sformatf("u%0d.done[%0d]", sel, j), done_w[sel], e.done);
      if (j == inject_at) begin
        send_r[sel] = 1'b1;
        data_r[sel] = 8'h00;
      end else begin
        send_r[sel] = 1'b0;
      end
      j++;
    end
    send_r[sel] = 1'b0;
  endtask

  // Main sequence: reset, table of single frames, then multi-cycle corner cases.
  initial begin
    logic [7:0] pace_bytes [9];
    int         waited;
    exp_t       e;

    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    send_r = 4'b0000;
    for (int i = 0; i < 4; i++) data_r[i] = 8'h00;

    vecs[0] = '{sel: 0, data: 8'h01, has_par: 1'b0, par_bit: 1'b0, len: 40};
    vecs[1] = '{sel: 1, data: 8'hA5, has_par: 1'b1, par_bit: 1'b0, len: 44};
    vecs[2] = '{sel: 2, data: 8'hA5, has_par: 1'b1, par_bit: 1'b1, len: 44};
    vecs[3] = '{sel: 1, data: 8'h01, has_par: 1'b1, par_bit: 1'b1, len: 44};
    vecs[4] = '{sel: 2, data: 8'h00, has_par: 1'b1, par_bit: 1'b1, len: 44};
    vecs[5] = '{sel: 0, data: 8'hC3, has_par: 1'b0, par_bit: 1'b0, len: 40};
    vecs[6] = '{sel: 3, data: 8'h5A, has_par: 1'b0, par_bit: 1'b0, len: 44};
    vecs[7] = '{sel: 1, data: 8'hFF, has_par: 1'b1, par_bit: 1'b0, len: 44};

    // Reset held three cycles, then idle line checks.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int u = 0; u < 4; u++) begin
      compareBit($sformatf("rst u%0d.tx", u), tx_w[u], 1'b1);
      compareBit($sformatf("rst u%0d.busy", u), busy_w[u], 1'b0);
      compareBit($sformatf("rst u%0d.done", u), done_w[u], 1'b0);
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      compareBit($sformatf("idle tx[%0d]", c), tx_w[0], 1'b1);
      compareBit($sformatf("idle busy[%0d]", c), busy_w[0], 1'b0);
    end

    // Table-driven single frames across all configurations.
    for (int v = 0; v < 8; v++) begin
      $display("[TB] vector %0d: unit %0d data 0x%02h", v, vecs[v].sel, vecs[v].data);
      applyStimulus(vecs[v].sel, vecs[v].data, vecs[v].has_par, vecs[v].par_bit,
                    vecs[v].len, 1'b1);
      checkOutput(vecs[v].sel, -1);
    end

    // A send on the last stop cycle (the STOP to IDLE edge) is dropped.
    applyStimulus(0, 8'h96, 1'b0, 1'b0, 40, 1'b1);
    checkOutput(0, 39);

    // Two stop bits: a mid-frame send is ignored, then a send on the first
    // idle cycle starts the next start bit on the following edge.
    applyStimulus(3, 8'hFF, 1'b0, 1'b0, 44, 1'b0);
    checkOutput(3, 20);
    applyStimulus(3, 8'h00, 1'b0, 1'b0, 44, 1'b1);
    checkOutput(3, -1);

    // Reset mid-frame: abandon the frame, line high, no done pulse.
    applyStimulus(0, 8'h00, 1'b0, 1'b0, 40, 1'b1);
    for (int j = 0; j < 12; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      e = exp_q.pop_front();
      compareBit($sformatf("mid tx[%0d]", j), tx_w[0], e.tx);
      compareBit($sformatf("mid busy[%0d]", j), busy_w[0], e.busy);
    end
    exp_q.delete();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    compareBit("midrst tx", tx_w[0], 1'b1);
    compareBit("midrst busy", busy_w[0], 1'b0);
    compareBit("midrst done", done_w[0], 1'b0);
    for (int c = 0; c < 45; c++) begin
      @(posedge clk);
      #1;
      compareBit($sformatf("postrst tx[%0d]", c), tx_w[0], 1'b1);
      compareBit($sformatf("postrst done[%0d]", c), done_w[0], 1'b0);
    end
    applyStimulus(0, 8'h3C, 1'b0, 1'b0, 40, 1'b1);
    checkOutput(0, -1);

    // Packetiser-style pacing: status byte then nonce bytes LSB first,
    // each sent as soon as tx_busy is seen low.
    pace_bytes[0] = 8'h01;
    for (int k = 1; k < 9; k++) pace_bytes[k] = 8'(k);
    for (int k = 0; k < 9; k++) begin
      waited = 0;
      while (busy_w[0] && waited < 60) begin
        @(posedge clk);
        #1;
        waited++;
      end
      checks++;
      if (waited > 1) begin
        fails++;
        $display("[TB] FAIL pace_gap[%0d]: got %0d wait cycles, expected at most 1", k, waited);
      end
      applyStimulus(0, pace_bytes[k], 1'b0, 1'b0, 40, (k == 8));
      checkOutput(0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
